// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter with a small input FIFO and fixed baud divider.
// Define MFP_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module mfp_uart_transmitter #(
  parameter int unsigned CLOCK_FREQUENCY = 50000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned DEPTH        = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef MFP_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                     state;
  logic [CNT_W-1:0]           baud_cnt;
  logic [2:0]                 bit_idx;
  logic [7:0]                 shift;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic [7:0]                 head;
  logic                       push;
  logic                       pop;
  logic                       bit_end;
`ifdef MFP_UART_TX_PARITY_EN
  logic                       parity;
`endif

  assign head       = mem[rd_ptr];
  assign tx_ready   = (count != (FIFO_DEPTH_LOG2+1)'(DEPTH));
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (baud_cnt == CNT_LAST);
  // The FSM pops either from IDLE or at the very end of STOP, so frames chain with no gap.
  assign pop        = (count != '0) && ((state == IDLE) || ((state == STOP) && bit_end));
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (FIFO_DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef MFP_UART_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= head;
`ifdef MFP_UART_TX_PARITY_EN
            parity   <= ^head;
`endif
            tx       <= 1'b0;
            baud_cnt <= '0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx       <= shift[0];
            shift    <= {1'b0, shift[7:1]};
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
              tx    <= parity;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx      <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`ifdef MFP_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx       <= 1'b1;
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              shift  <= head;
`ifdef MFP_UART_TX_PARITY_EN
              parity <= ^head;
`endif
              tx     <= 1'b0;
              state  <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Scoreboard bench: accepted bytes are queued, a line monitor decodes frames and compares.
module tb_mfp_uart_transmitter;

  localparam int CPB = 16;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  int         checks = 0;
  int         errors = 0;
  longint     cyc = 0;
  logic [7:0] sb[$];
  longint     starts[$];
  bit         mon_busy = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  mfp_uart_transmitter #(
    .CLOCK_FREQUENCY(1600),
    .BAUD_RATE(100),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NB-1:0] make_pat(input logic [7:0] b);
`ifdef MFP_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  // Line monitor: every clock of every bit must match the expected frame image.
  initial begin : monitor
    int         idx;
    int         bad;
    bit         orphan;
    logic [NB-1:0] pat;
    logic [7:0] exp_b;
    logic [7:0] rx;
    idx = 0; bad = 0; orphan = 1'b0; pat = '1; exp_b = '0; rx = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_busy = 1'b0;
      end else begin
        if (!mon_busy && tx === 1'b0) begin
          mon_busy = 1'b1;
          idx = 0;
          bad = 0;
          rx = '0;
          starts.push_back(cyc);
          if (sb.size() == 0) begin
            orphan = 1'b1;
            exp_b = '0;
            checks++;
            errors++;
            $display("FAIL unexpected_frame: start bit at cycle %0d, expected idle line", cyc);
          end else begin
            orphan = 1'b0;
            exp_b = sb.pop_front();
          end
          pat = make_pat(exp_b);
        end
        if (mon_busy) begin
          if (tx !== pat[idx / CPB]) bad++;
          if ((idx % CPB) == CPB / 2 && (idx / CPB) >= 1 && (idx / CPB) <= 8)
            rx[idx / CPB - 1] = tx;
          idx++;
          if (idx == FRAME) begin
            mon_busy = 1'b0;
            if (!orphan) begin
              checks++;
              if (bad != 0 || rx !== exp_b) begin
                errors++;
                $display("FAIL frame: decoded %02h with %0d bad samples, expected %02h with 0",
                         rx, bad, exp_b);
              end
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, output bit acc);
    @(negedge clock);
    tx_data  = b;
    tx_valid = 1'b1;
    acc      = tx_ready;
    if (acc) sb.push_back(b);
    @(posedge clock);
  endtask

  task automatic drop_valid();
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || mon_busy || busy) && n < 4000) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk(name, (n >= 4000) ? 1 : 0, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    int n;
    int burst_cnt[5] = '{1, 1, 2, 3, 4};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_state", {tx, tx_ready, busy, fifo_count}, 6'b110000);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      chk("idle_state", {tx, tx_ready, busy, fifo_count}, 6'b110000);
    end

    // Single byte: latency, frame length, busy release.
    send(8'hA5, acc);
    #1;
    chk("a5_accept", acc, 1);
    chk("a5_push_tx", tx, 1);
    chk("a5_push_count", fifo_count, 1);
    chk("a5_push_busy", busy, 1);
    drop_valid();
    @(posedge clock);
    #1;
    chk("a5_latency_tx", tx, 0);
    chk("a5_pop_count", fifo_count, 0);
    repeat (FRAME - 1) @(posedge clock);
    #1;
    chk("a5_busy_last_stop_clk", busy, 1);
    @(posedge clock);
    #1;
    chk("a5_busy_after_frame", busy, 0);
    chk("a5_tx_after_frame", tx, 1);
    drain("a5_drain_timeout");

    // Burst: fifth byte fits because the first one is popped the cycle after its push.
    starts.delete();
    for (int i = 0; i < 5; i++) begin
      send(8'(i + 1), acc);
      #1;
      chk("burst_accept", acc, 1);
      chk("burst_count", fifo_count, burst_cnt[i]);
    end
    for (int b = 6; b <= 11; b++) begin
      n = 0;
      do begin
        send(8'(b), acc);
        n++;
        #1;
        if (b == 6 && n == 1) begin
          chk("full_ready", acc, 0);
          chk("full_count", fifo_count, 4);
        end
      end while (!acc && n < 400);
      chk("hold_accept", acc, 1);
      chk("hold_count", fifo_count, 4);
    end
    drop_valid();
    drain("burst_drain_timeout");
    chk("burst_frames", starts.size(), 11);
    for (int i = 1; i < starts.size(); i++)
      chk("burst_gap", starts[i] - starts[i-1], FRAME);

    // Reset in the middle of a data bit with two bytes still queued.
    send(8'h5A, acc);
    chk("rst_accept0", acc, 1);
    send(8'h11, acc);
    chk("rst_accept1", acc, 1);
    send(8'h22, acc);
    chk("rst_accept2", acc, 1);
    drop_valid();
    repeat (40) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_count", fifo_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clock);
      #1;
      chk("post_reset_idle", {tx, busy, fifo_count}, 5'b10000);
    end

    // Odd and even weight bytes exercise both parity values when enabled.
    send(8'h07, acc);
    chk("b07_accept", acc, 1);
    drop_valid();
    drain("b07_drain_timeout");
    send(8'h03, acc);
    chk("b03_accept", acc, 1);
    drop_valid();
    drain("b03_drain_timeout");

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
